// File: rtl/ata_pio_seq.sv
`default_nettype none
// ============================================================================
// Module : ata_pio_seq
// PIO bus-cycle sequencer with NDEV timing sets, IORDY wait insertion and
// IORDY timeout error termination.
// Rev    : 1.0
// ============================================================================
module ata_pio_seq #(
    parameter int TWIDTH         = 8,
    parameter int NDEV           = 2,
    parameter int TSW            = (NDEV > 1) ? $clog2(NDEV) : 1,
    parameter int PIO_mode0_T1   = 6,
    parameter int PIO_mode0_T2   = 28,
    parameter int PIO_mode0_T4   = 2,
    parameter int PIO_mode0_Teoc = 23,
    parameter int IORDY_TO       = 1023
) (
    input  logic                   CLK_I,
    input  logic                   nReset,
    input  logic                   RST_I,
    input  logic                   req,
    input  logic                   we,
    input  logic [3:0]             a,
    input  logic [15:0]            d,
    input  logic [TSW-1:0]         tsel,
    input  logic [NDEV*TWIDTH-1:0] T1,
    input  logic [NDEV*TWIDTH-1:0] T2,
    input  logic [NDEV*TWIDTH-1:0] T4,
    input  logic [NDEV*TWIDTH-1:0] Teoc,
    input  logic [NDEV-1:0]        IORDYen,
    output logic                   ack,
    output logic                   err,
    output logic                   busy,
    output logic [15:0]            q,
    input  logic [15:0]            DDi,
    output logic [15:0]            DDo,
    output logic                   DDoe,
    output logic [2:0]             DA,
    output logic                   CS0n,
    output logic                   CS1n,
    output logic                   DIORn,
    output logic                   DIOWn,
    input  logic                   IORDY
);

    localparam int            WW    = $clog2(IORDY_TO + 1);
    localparam logic [WW-1:0] WLAST = WW'(IORDY_TO - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETUP  = 3'd1,
        S_STROBE = 3'd2,
        S_WAIT   = 3'd3,
        S_HOLD   = 3'd4
    } state_t;

    logic [TWIDTH-1:0] t1_arr   [NDEV];
    logic [TWIDTH-1:0] t2_arr   [NDEV];
    logic [TWIDTH-1:0] t4_arr   [NDEV];
    logic [TWIDTH-1:0] teoc_arr [NDEV];

    genvar k;
    generate
        for (k = 0; k < NDEV; k++) begin : g_unpack
            assign t1_arr[k]   = T1[k*TWIDTH +: TWIDTH];
            assign t2_arr[k]   = T2[k*TWIDTH +: TWIDTH];
            assign t4_arr[k]   = T4[k*TWIDTH +: TWIDTH];
            assign teoc_arr[k] = Teoc[k*TWIDTH +: TWIDTH];
        end
    endgenerate

    state_t            state_q, state_d;
    logic [TWIDTH-1:0] cnt_q, cnt_d, c4_q, c4_d, ce_q, ce_d;
    logic [TWIDTH-1:0] t2_q, t2_d, t4_q, t4_d, teoc_q, teoc_d;
    logic [WW-1:0]     wcnt_q, wcnt_d;
    logic              ien_q, ien_d, we_q, we_d;
    logic              diorn_q, diorn_d, diown_q, diown_d;
    logic              cs0n_q, cs0n_d, cs1n_q, cs1n_d;
    logic [2:0]        da_q, da_d;
    logic [15:0]       ddo_q, ddo_d, q_q, q_d;
    logic              ddoe_q, ddoe_d, busy_q, busy_d, ack_q, ack_d, err_q, err_d;
    logic              iordy_m_q, iordy_s_q;
    logic              rel_ok, rel_to;
    logic [TSW-1:0]    sel;

    // Out-of-range selects fall back to timing set 0
    always_comb sel = (int'(tsel) < NDEV) ? tsel : '0;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        c4_d    = c4_q;
        ce_d    = ce_q;
        wcnt_d  = wcnt_q;
        t2_d    = t2_q;
        t4_d    = t4_q;
        teoc_d  = teoc_q;
        ien_d   = ien_q;
        we_d    = we_q;
        diorn_d = diorn_q;
        diown_d = diown_q;
        cs0n_d  = cs0n_q;
        cs1n_d  = cs1n_q;
        da_d    = da_q;
        ddo_d   = ddo_q;
        ddoe_d  = ddoe_q;
        busy_d  = busy_q;
        q_d     = q_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        rel_ok  = 1'b0;
        rel_to  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (req) begin
                    state_d = S_SETUP;
                    busy_d  = 1'b1;
                    we_d    = we;
                    cs0n_d  = a[3];
                    cs1n_d  = ~a[3];
                    da_d    = a[2:0];
                    ddo_d   = d;
                    ddoe_d  = we;
                    cnt_d   = t1_arr[sel];
                    t2_d    = t2_arr[sel];
                    t4_d    = t4_arr[sel];
                    teoc_d  = teoc_arr[sel];
                    ien_d   = IORDYen[sel];
                end
            end
            S_SETUP: begin
                if (cnt_q == '0) begin
                    state_d = S_STROBE;
                    cnt_d   = t2_q;
                    diorn_d = we_q;
                    diown_d = ~we_q;
                end else begin
                    cnt_d = cnt_q - TWIDTH'(1);
                end
            end
            S_STROBE: begin
                if (cnt_q == '0) begin
                    if (ien_q && !iordy_s_q) begin
                        state_d = S_WAIT;
                        wcnt_d  = '0;
                    end else begin
                        rel_ok = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - TWIDTH'(1);
                end
            end
            S_WAIT: begin
                if (iordy_s_q) begin
                    rel_ok = 1'b1;
                end else if (wcnt_q == WLAST) begin
                    rel_to = 1'b1;
                end else begin
                    wcnt_d = wcnt_q + WW'(1);
                end
            end
            S_HOLD: begin
                // Both hold counters saturate at zero; exit once both have expired
                if (c4_q == '0) ddoe_d = 1'b0;
                else            c4_d   = c4_q - TWIDTH'(1);
                if (ce_q != '0) ce_d   = ce_q - TWIDTH'(1);
                if (c4_q == '0 && ce_q == '0) begin
                    state_d = S_IDLE;
                    cs0n_d  = 1'b1;
                    cs1n_d  = 1'b1;
                    busy_d  = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (rel_ok || rel_to) begin
            state_d = S_HOLD;
            diorn_d = 1'b1;
            diown_d = 1'b1;
            c4_d    = t4_q;
            ce_d    = teoc_q;
            ack_d   = rel_ok;
            err_d   = rel_to;
            if (rel_ok && !we_q) q_d = DDi;
        end
    end

    always_ff @(posedge CLK_I or negedge nReset) begin
        if (!nReset || RST_I) begin
            state_q   <= S_IDLE;
            cnt_q     <= TWIDTH'(PIO_mode0_T1);
            c4_q      <= '0;
            ce_q      <= '0;
            wcnt_q    <= '0;
            t2_q      <= TWIDTH'(PIO_mode0_T2);
            t4_q      <= TWIDTH'(PIO_mode0_T4);
            teoc_q    <= TWIDTH'(PIO_mode0_Teoc);
            ien_q     <= 1'b0;
            we_q      <= 1'b0;
            diorn_q   <= 1'b1;
            diown_q   <= 1'b1;
            cs0n_q    <= 1'b1;
            cs1n_q    <= 1'b1;
            da_q      <= '0;
            ddo_q     <= '0;
            ddoe_q    <= 1'b0;
            busy_q    <= 1'b0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            q_q       <= '0;
            iordy_m_q <= 1'b0;
            iordy_s_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            c4_q      <= c4_d;
            ce_q      <= ce_d;
            wcnt_q    <= wcnt_d;
            t2_q      <= t2_d;
            t4_q      <= t4_d;
            teoc_q    <= teoc_d;
            ien_q     <= ien_d;
            we_q      <= we_d;
            diorn_q   <= diorn_d;
            diown_q   <= diown_d;
            cs0n_q    <= cs0n_d;
            cs1n_q    <= cs1n_d;
            da_q      <= da_d;
            ddo_q     <= ddo_d;
            ddoe_q    <= ddoe_d;
            busy_q    <= busy_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
            q_q       <= q_d;
            iordy_m_q <= IORDY;
            iordy_s_q <= iordy_m_q;
        end
    end

    assign ack   = ack_q;
    assign err   = err_q;
    assign busy  = busy_q;
    assign q     = q_q;
    assign DDo   = ddo_q;
    assign DDoe  = ddoe_q;
    assign DA    = da_q;
    assign CS0n  = cs0n_q;
    assign CS1n  = cs1n_q;
    assign DIORn = diorn_q;
    assign DIOWn = diown_q;

endmodule
`default_nettype wire

// File: tb/tb_ata_pio_seq.sv
`default_nettype none
// ============================================================================
// Module : tb_ata_pio_seq
// Self-checking bench: timeline model of each transfer plus directed checks.
// Rev    : 1.0
// ============================================================================
module tb_ata_pio_seq;

    localparam int TW = 8;
    localparam int ND = 2;
    localparam int TO = 15;

    logic              CLK_I  = 1'b0;
    logic              nReset = 1'b1;
    logic              RST_I  = 1'b0;
    logic              req    = 1'b0;
    logic              we     = 1'b0;
    logic [3:0]        a      = '0;
    logic [15:0]       d      = '0;
    logic [0:0]        tsel   = '0;
    logic [ND*TW-1:0]  T1     = {8'd1, 8'd6};
    logic [ND*TW-1:0]  T2     = {8'd3, 8'd28};
    logic [ND*TW-1:0]  T4     = {8'd1, 8'd2};
    logic [ND*TW-1:0]  Teoc   = {8'd2, 8'd23};
    logic [ND-1:0]     IORDYen = '0;
    logic [15:0]       DDi    = '0;
    logic              IORDY  = 1'b1;
    logic              ack, err, busy, DDoe, CS0n, CS1n, DIORn, DIOWn;
    logic [15:0]       q, DDo;
    logic [2:0]        DA;

    ata_pio_seq #(.TWIDTH(TW), .NDEV(ND), .IORDY_TO(TO)) dut (
        .CLK_I(CLK_I), .nReset(nReset), .RST_I(RST_I), .req(req), .we(we),
        .a(a), .d(d), .tsel(tsel), .T1(T1), .T2(T2), .T4(T4), .Teoc(Teoc),
        .IORDYen(IORDYen), .ack(ack), .err(err), .busy(busy), .q(q),
        .DDi(DDi), .DDo(DDo), .DDoe(DDoe), .DA(DA), .CS0n(CS0n), .CS1n(CS1n),
        .DIORn(DIORn), .DIOWn(DIOWn), .IORDY(IORDY)
    );

    always #5 CLK_I = ~CLK_I;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- timeline model ----------------
    // Each transfer is described by the edges at which its phases begin:
    // A accept, F strobe fall, S nominal strobe end, R strobe release,
    // Hd data-enable drop, I return to idle.
    int          cyc = 0;
    bit          m_act = 0, m_rk = 0, m_err = 0, m_we = 0, m_ien = 0;
    int          m_a_e = 0, m_f = 0, m_s = 0, m_r = 0, m_hd = 0, m_i = 0, m_t4 = 0, m_teoc = 0;
    logic [3:0]  m_a = '0;
    logic [15:0] m_d = '0, m_q = '0;
    bit          h1 = 0, h2 = 0;

    always @(posedge CLK_I) begin
        int sel, t1v, t2v, mx;
        bit rel, rto;
        cyc++;
        if (!nReset || RST_I) begin
            m_act = 0; m_q = '0; h1 = 0; h2 = 0;
        end else begin
            rel = 0; rto = 0;
            if (m_act && !m_rk && cyc >= m_s) begin
                if (!m_ien || h2)        rel = 1;
                else if (cyc == m_s + TO) begin rel = 1; rto = 1; end
            end
            if (rel) begin
                mx     = (m_t4 > m_teoc) ? m_t4 : m_teoc;
                m_rk   = 1; m_err = rto; m_r = cyc;
                m_hd   = cyc + m_t4 + 1;
                m_i    = cyc + mx + 1;
                if (!rto && !m_we) m_q = DDi;
            end
            h2 = h1; h1 = IORDY;
            if (req && (!m_act || (m_rk && cyc > m_i))) begin
                sel    = (int'(tsel) < ND) ? int'(tsel) : 0;
                t1v    = int'(T1[sel*TW +: TW]);
                t2v    = int'(T2[sel*TW +: TW]);
                m_t4   = int'(T4[sel*TW +: TW]);
                m_teoc = int'(Teoc[sel*TW +: TW]);
                m_ien  = IORDYen[sel];
                m_act  = 1; m_rk = 0; m_a_e = cyc;
                m_f    = cyc + t1v + 1;
                m_s    = m_f + t2v + 1;
                m_we   = we; m_a = a; m_d = d;
            end
        end
    end

    always @(negedge CLK_I) begin
        bit live, e_busy, e_str, e_ddoe;
        live   = nReset && m_act;
        e_busy = live && (!m_rk || cyc < m_i);
        e_str  = live && cyc >= m_f && (!m_rk || cyc < m_r);
        e_ddoe = live && m_we && (!m_rk || cyc < m_hd);
        chk("busy",  busy,  e_busy);
        chk("DIORn", DIORn, !(e_str && !m_we));
        chk("DIOWn", DIOWn, !(e_str && m_we));
        chk("DDoe",  DDoe,  e_ddoe);
        chk("ack",   ack,   live && m_rk && cyc == m_r && !m_err);
        chk("err",   err,   live && m_rk && cyc == m_r && m_err);
        chk("CS0n",  CS0n,  !(e_busy && !m_a[3]));
        chk("CS1n",  CS1n,  !(e_busy && m_a[3]));
        chk("q",     q,     nReset ? m_q : 16'h0);
        if (e_busy)  chk("DA",  DA,  m_a[2:0]);
        if (e_ddoe)  chk("DDo", DDo, m_d);
        if (!nReset) begin
            chk("DA_rst",  DA,  3'd0);
            chk("DDo_rst", DDo, 16'h0);
        end
    end

    // ---------------- event tracker for literal checks ----------------
    int falls[$];
    int rises[$];
    int ack_cnt = 0, err_cnt = 0, busy_rise = -1, busy_fall = -1, ddoe_rise = -1, ddoe_fall = -1;
    bit cs0_seen = 0, cs1_seen = 0;
    logic p_str = 1'b1, p_busy = 1'b0, p_ddoe = 1'b0;

    always @(negedge CLK_I) begin
        logic s;
        s = DIORn & DIOWn;
        if (p_str && !s) falls.push_back(cyc);
        if (!p_str && s) rises.push_back(cyc);
        if (ack) ack_cnt++;
        if (err) err_cnt++;
        if (!p_busy && busy) busy_rise = cyc;
        if (p_busy && !busy) busy_fall = cyc;
        if (!p_ddoe && DDoe) ddoe_rise = cyc;
        if (p_ddoe && !DDoe) ddoe_fall = cyc;
        if (!CS0n) cs0_seen = 1;
        if (!CS1n) cs1_seen = 1;
        p_str = s; p_busy = busy; p_ddoe = DDoe;
    end

    function automatic int qat(input int qq[$], input int i);
        return (qq.size() > i) ? qq[i] : -1000;
    endfunction

    task automatic clr();
        falls.delete(); rises.delete();
        ack_cnt = 0; err_cnt = 0; busy_rise = -1; busy_fall = -1;
        ddoe_rise = -1; ddoe_fall = -1; cs0_seen = 0; cs1_seen = 0;
    endtask

    task automatic wait_done();
        bit got;
        got = 0;
        for (int i = 0; i < 2000 && !got; i++) begin
            @(negedge CLK_I);
            if (ack || err) got = 1;
        end
        chk("done_timeout", got, 1'b1);
    endtask

    task automatic wait_idle();
        bit got;
        got = 0;
        for (int i = 0; i < 2000 && !got; i++) begin
            @(negedge CLK_I);
            if (!busy) got = 1;
        end
        chk("idle_timeout", got, 1'b1);
        repeat (2) @(negedge CLK_I);
    endtask

    task automatic wait_strobe();
        bit got;
        got = 0;
        for (int i = 0; i < 2000 && !got; i++) begin
            @(negedge CLK_I);
            if (!(DIORn & DIOWn)) got = 1;
        end
        chk("strobe_timeout", got, 1'b1);
    endtask

    task automatic start(input logic w, input logic [3:0] aa, input logic [15:0] dd, input logic ts);
        clr();
        we = w; a = aa; d = dd; tsel = ts; req = 1'b1;
    endtask

    task automatic xfer(input logic w, input logic [3:0] aa, input logic [15:0] dd, input logic ts);
        start(w, aa, dd, ts);
        wait_done();
        req = 1'b0;
        wait_idle();
    endtask

    initial begin
        #1 nReset = 1'b0;
        #1;
        chk("rst_DIORn", DIORn, 1'b1);
        chk("rst_DIOWn", DIOWn, 1'b1);
        chk("rst_CS",    {CS0n, CS1n}, 2'b11);
        chk("rst_busy",  {busy, ack, err, DDoe}, 4'b0000);
        chk("rst_q",     q, 16'h0);
        repeat (3) @(negedge CLK_I);
        nReset = 1'b1;
        repeat (2) @(negedge CLK_I);

        // Mode-0 read on set 0
        DDi = 16'hA55A;
        xfer(1'b0, 4'b0111, 16'h0, 1'b0);
        chk("t1_q",      q, 16'hA55A);
        chk("t1_setup",  qat(falls, 0) - busy_rise, 7);
        chk("t1_strobe", qat(rises, 0) - qat(falls, 0), 29);
        chk("t1_busy",   busy_fall - busy_rise, 60);
        chk("t1_ack",    ack_cnt, 1);
        chk("t1_cs0",    {cs0_seen, cs1_seen}, 2'b10);

        // Write on set 1
        xfer(1'b1, 4'b1110, 16'h1234, 1'b1);
        chk("t2_strobe", qat(rises, 0) - qat(falls, 0), 4);
        chk("t2_ddoe_r", ddoe_rise - busy_rise, 0);
        chk("t2_ddoe_f", ddoe_fall - qat(rises, 0), 2);
        chk("t2_idle",   busy_fall - qat(rises, 0), 3);
        chk("t2_cs1",    {cs0_seen, cs1_seen}, 2'b01);
        chk("t2_ack",    ack_cnt, 1);
        chk("t2_q_kept", q, 16'hA55A);

        // IORDY low for 10 cycles past the end of T2
        IORDYen = 2'b10; IORDY = 1'b0; DDi = 16'h5AA5;
        start(1'b0, 4'b0011, 16'h0, 1'b1);
        wait_strobe();
        repeat (13) @(negedge CLK_I);
        IORDY = 1'b1;
        wait_done();
        req = 1'b0;
        wait_idle();
        chk("t3_strobe", qat(rises, 0) - qat(falls, 0), 16);
        chk("t3_ack",    {ack_cnt[7:0], err_cnt[7:0]}, 16'h0100);
        chk("t3_q",      q, 16'h5AA5);

        // IORDY stuck low: timeout
        IORDY = 1'b0; DDi = 16'hFFFF;
        xfer(1'b0, 4'b0001, 16'h0, 1'b1);
        chk("t4_strobe", qat(rises, 0) - qat(falls, 0), 19);
        chk("t4_err",    err_cnt, 1);
        chk("t4_noack",  ack_cnt, 0);
        chk("t4_q",      q, 16'h5AA5);
        IORDY = 1'b1; IORDYen = 2'b00;

        // Back-to-back reads with req held
        DDi = 16'h1357;
        start(1'b0, 4'b0101, 16'h0, 1'b0);
        wait_done();
        chk("t5_q1", q, 16'h1357);
        DDi = 16'h2468;
        wait_done();
        req = 1'b0;
        wait_idle();
        chk("t5_gap",    qat(falls, 1) - qat(rises, 0), 32);
        chk("t5_period", qat(falls, 1) - qat(falls, 0), 61);
        chk("t5_acks",   ack_cnt, 2);
        chk("t5_q2",     q, 16'h2468);

        // Async reset in the middle of a write strobe
        start(1'b1, 4'b0001, 16'hBEEF, 1'b0);
        wait_strobe();
        repeat (5) @(negedge CLK_I);
        @(posedge CLK_I);
        #2 nReset = 1'b0;
        #1;
        chk("t6_DIOWn", DIOWn, 1'b1);
        chk("t6_DDoe",  DDoe, 1'b0);
        chk("t6_CS",    {CS0n, CS1n}, 2'b11);
        chk("t6_busy",  busy, 1'b0);
        req = 1'b0;
        repeat (3) @(negedge CLK_I);
        nReset = 1'b1;
        repeat (2) @(negedge CLK_I);
        chk("t6_noack", ack_cnt + err_cnt, 0);
        DDi = 16'h0F0F;
        xfer(1'b0, 4'b1010, 16'h0, 1'b1);
        chk("t6_after_ack", ack_cnt, 1);
        chk("t6_after_q",   q, 16'h0F0F);

        // All-ones strobe width; timing change mid-transfer must not matter
        T2 = {8'd255, 8'd28};
        DDi = 16'hC3C3;
        start(1'b0, 4'b0100, 16'h0, 1'b1);
        wait_strobe();
        repeat (10) @(negedge CLK_I);
        T2 = {8'd3, 8'd28};
        wait_done();
        req = 1'b0;
        wait_idle();
        chk("t7_strobe", qat(rises, 0) - qat(falls, 0), 256);
        chk("t7_q",      q, 16'hC3C3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        n_bad++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
